// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-wide memory bus master: default widths,
// wait-counter width, word byte order and the sequencer state encoding.
package mem_bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  // Wide enough for WAIT_CYCLES in 0..15.
  localparam int WAIT_W = 4;

  // Words are stored low byte first (low byte at addr, high byte at addr+1).
  localparam bit LITTLE_ENDIAN = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Byte lane (0 = low byte of the 16-bit value) carried by a bus beat.
  // Byte accesses always use the low lane.
  function automatic logic lane_of(input logic word, input logic second_beat);
    return word & (second_beat ^ ~LITTLE_ENDIAN);
  endfunction

endpackage

// File: rtl/mem_bus_master.sv
// Initiator for a single-port byte-wide memory bus. Accepts byte/word
// read/write requests over valid/ready, sequences one or two bus beats
// (each held WAIT_CYCLES+1 cycles) and returns a one-cycle response pulse.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_word,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                resp_valid,
  output logic [2*DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0]   bus_addr,
  inout  wire  [DATA_W-1:0]   bus_data,
  output logic                bus_we,
  output logic                bus_cs
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic                word_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [2*DATA_W-1:0] rdata_q;
  logic [2*DATA_W-1:0] rdata_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]   dout;
  logic                cur_lane;
  logic                beat_done;

  // The data driver is enabled by the registered write strobe, so the bus
  // is only driven while the memory is being told to capture it.
  assign bus_data = bus_we ? dout : {DATA_W{1'bz}};

  // Current beat's byte lane, end-of-beat detect and merged read data.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_lane   = lane_of(word_q, state == BEAT1);
    beat_done  = (wait_cnt == WAIT_LAST);
    rdata_next = rdata_q;
    rdata_next[int'(cur_lane)*DATA_W +: DATA_W] = bus_data;
  end

  // Request sequencer: owns all registered outputs and the beat wait counter.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      word_q     <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt   <= '0;
      dout       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_cs     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            write_q   <= req_write;
            word_q    <= req_word;
            wdata_q   <= req_wdata;
            rdata_q   <= '0;
            wait_cnt  <= '0;
            bus_addr  <= req_addr;
            bus_cs    <= 1'b1;
            bus_we    <= req_write;
            dout      <= req_wdata[int'(lane_of(req_word, 1'b0))*DATA_W +: DATA_W];
            req_ready <= 1'b0;
            state     <= BEAT0;
          end
        end

        BEAT0, BEAT1: begin
          if (!beat_done) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
            if (!write_q) rdata_q <= rdata_next;
            if (state == BEAT0 && word_q) begin
              // Second byte lives at the next address; wraps at the top.
              bus_addr <= addr_q + ADDR_W'(1);
              dout     <= wdata_q[int'(lane_of(1'b1, 1'b1))*DATA_W +: DATA_W];
              state    <= BEAT1;
            end else begin
              bus_cs     <= 1'b0;
              bus_we     <= 1'b0;
              bus_addr   <= '0;
              resp_valid <= 1'b1;
              resp_rdata <= write_q ? '0 : rdata_next;
              state      <= RESP;
            end
          end
        end

        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: a WAIT_CYCLES=0 instance runs a
// table of directed requests against a byte memory model; a WAIT_CYCLES=2
// instance shares the request inputs and is checked for its stretched beats.
module tb_mem_bus_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic        req_word;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;

  // Instance with no wait states.
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] bus_addr;
  logic        bus_we;
  logic        bus_cs;
  tri1  [7:0]  bus_data;

  // Instance with two wait states per beat.
  logic        w2_req_ready;
  logic        w2_resp_valid;
  logic [15:0] w2_resp_rdata;
  logic [15:0] w2_bus_addr;
  logic        w2_bus_we;
  logic        w2_bus_cs;
  tri1  [7:0]  w2_bus_data;

  mem_bus_master #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(0)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_word   (req_word),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_we     (bus_we),
    .bus_cs     (bus_cs)
  );

  mem_bus_master #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (w2_req_ready),
    .req_write  (req_write),
    .req_word   (req_word),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (w2_resp_valid),
    .resp_rdata (w2_resp_rdata),
    .bus_addr   (w2_bus_addr),
    .bus_data   (w2_bus_data),
    .bus_we     (w2_bus_we),
    .bus_cs     (w2_bus_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memories: combinational read when selected, capture on posedge.
  logic [7:0] mem0 [0:65535];
  logic [7:0] mem2 [0:65535];
  int         wr_cnt0;
  logic [15:0] last_wr_addr0;
  logic [7:0]  last_wr_data0;

  assign bus_data    = (bus_cs && !bus_we)       ? mem0[bus_addr]    : 8'hzz;
  assign w2_bus_data = (w2_bus_cs && !w2_bus_we) ? mem2[w2_bus_addr] : 8'hzz;

  always @(posedge clk) begin
    if (bus_cs && bus_we) begin
      mem0[bus_addr] <= bus_data;
      last_wr_addr0  <= bus_addr;
      last_wr_data0  <= bus_data;
      wr_cnt0++;
    end
    if (w2_bus_cs && w2_bus_we) mem2[w2_bus_addr] <= w2_bus_data;
  end

  // Write strobe must never appear without chip select.
  int we_viol;
  always @(negedge clk) begin
    if (bus_we && !bus_cs) we_viol++;
    if (w2_bus_we && !w2_bus_cs) we_viol++;
  end

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0] trace [$];
  int          ready_high;

  // Issue one request, then watch the selected instance on falling edges.
  // lat = index of the falling edge (1 = first after acceptance) with resp_valid.
  task automatic do_req(input bit sel, input logic wr, input logic word,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat, output logic [15:0] rdata);
    @(negedge clk);
    check("ready_before_req", 32'(sel ? w2_req_ready : req_ready), 32'd1);
    req_write = wr;
    req_word  = word;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat        = 0;
    rdata      = '0;
    ready_high = 0;
    trace.delete();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (sel ? w2_bus_cs : bus_cs) trace.push_back(sel ? w2_bus_addr : bus_addr);
      if (sel ? w2_req_ready : req_ready) ready_high++;
      if (sel ? w2_resp_valid : resp_valid) begin
        lat   = k;
        rdata = sel ? w2_resp_rdata : resp_rdata;
        break;
      end
    end
    @(negedge clk);
    check("resp_one_cycle", 32'(sel ? w2_resp_valid : resp_valid), 32'd0);
    check("ready_after_resp", 32'(sel ? w2_req_ready : req_ready), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          wr_before;
    int          resp_seen;
    logic [15:0] rdata;
    logic [15:0] exp_last;

    n_checks = 0;
    n_fail   = 0;
    we_viol  = 0;
    wr_cnt0  = 0;
    last_wr_addr0 = '0;
    last_wr_data0 = '0;
    for (int a = 0; a < 65536; a++) begin
      mem0[a] = 8'h00;
      mem2[a] = 8'h00;
    end
    mem0[16'h1000] = 8'h08; mem0[16'h1001] = 8'h60;
    mem2[16'h1000] = 8'h08; mem2[16'h1001] = 8'h60;

    //            wr    word  addr      wdata     exp_rdata lat
    vecs[0] = '{1'b0, 1'b1, 16'h1000, 16'h0000, 16'h6008, 3};
    vecs[1] = '{1'b1, 1'b0, 16'h0008, 16'h005A, 16'h0000, 2};
    vecs[2] = '{1'b0, 1'b0, 16'h0008, 16'h0000, 16'h005A, 2};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 3};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hBEEF, 3};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00BE, 2};
    vecs[6] = '{1'b1, 1'b0, 16'h3000, 16'h77C3, 16'h0000, 2};
    vecs[7] = '{1'b0, 1'b1, 16'h3000, 16'h0000, 16'h00C3, 3};
    vecs[8] = '{1'b1, 1'b1, 16'h2000, 16'h1234, 16'h0000, 3};
    vecs[9] = '{1'b0, 1'b0, 16'h2001, 16'h0000, 16'h0012, 2};

    // Reset then idle.
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_word  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_bus_cs",     32'(bus_cs),     32'd0);
    check("rst_bus_we",     32'(bus_we),     32'd0);
    check("rst_bus_data_z", 32'(bus_data),   32'h0000_00FF);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_bus_addr",   32'(bus_addr),   32'd0);
    check("rst_w2_ready",   32'(w2_req_ready), 32'd1);

    // Table of requests on the zero-wait instance.
    for (int i = 0; i < 10; i++) begin
      wr_before = wr_cnt0;
      do_req(1'b0, vecs[i].wr, vecs[i].word, vecs[i].addr, vecs[i].wdata, lat, rdata);
      exp_last = vecs[i].word ? vecs[i].addr + 16'd1 : vecs[i].addr;
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      check($sformatf("v%0d_ready_low", i), 32'(ready_high), 32'd0);
      check($sformatf("v%0d_write_beats", i), 32'(wr_cnt0 - wr_before),
            vecs[i].wr ? (vecs[i].word ? 32'd2 : 32'd1) : 32'd0);
      check($sformatf("v%0d_beats", i), 32'(trace.size()), vecs[i].word ? 32'd2 : 32'd1);
      if (trace.size() > 0) begin
        check($sformatf("v%0d_first_addr", i), 32'(trace[0]), 32'(vecs[i].addr));
        check($sformatf("v%0d_last_addr", i), 32'(trace[trace.size()-1]), 32'(exp_last));
      end
      if (vecs[i].wr) begin
        check($sformatf("v%0d_wr_addr", i), 32'(last_wr_addr0), 32'(exp_last));
        check($sformatf("v%0d_wr_data", i), 32'(last_wr_data0),
              vecs[i].word ? 32'(vecs[i].wdata[15:8]) : 32'(vecs[i].wdata[7:0]));
      end
    end
    check("wrap_mem_ffff", 32'(mem0[16'hFFFF]), 32'h0000_00EF);
    check("wrap_mem_0000", 32'(mem0[16'h0000]), 32'h0000_00BE);
    check("byte_wr_no_hi", 32'(mem0[16'h3001]), 32'h0000_0000);

    // Wait-state instance: each beat held three cycles.
    repeat (20) @(negedge clk);
    do_req(1'b1, 1'b0, 1'b1, 16'h1000, 16'h0000, lat, rdata);
    check("w2_latency",   32'(lat),          32'd7);
    check("w2_rdata",     32'(rdata),        32'h0000_6008);
    check("w2_ready_low", 32'(ready_high),   32'd0);
    check("w2_beats",     32'(trace.size()), 32'd6);
    if (trace.size() == 6) begin
      for (int j = 0; j < 6; j++)
        check($sformatf("w2_addr_%0d", j), 32'(trace[j]), (j < 3) ? 32'h1000 : 32'h1001);
    end

    // Reset during the second beat of a word write.
    repeat (20) @(negedge clk);
    @(negedge clk);
    wr_before = wr_cnt0;
    req_write = 1'b1;
    req_word  = 1'b1;
    req_addr  = 16'h4000;
    req_wdata = 16'hA1B2;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("mid_bus_cs",   32'(bus_cs),   32'd1);
    check("mid_bus_addr", 32'(bus_addr), 32'h4001);
    rst_n = 1'b0;
    #1;
    check("arst_bus_cs",     32'(bus_cs),     32'd0);
    check("arst_bus_we",     32'(bus_we),     32'd0);
    check("arst_bus_data_z", 32'(bus_data),   32'h0000_00FF);
    check("arst_req_ready",  32'(req_ready),  32'd1);
    check("arst_bus_addr",   32'(bus_addr),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resp_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    check("arst_no_resp",   32'(resp_seen),          32'd0);
    check("arst_ready",     32'(req_ready),          32'd1);
    check("arst_wr_beats",  32'(wr_cnt0 - wr_before), 32'd1);
    check("arst_mem_lo",    32'(mem0[16'h4000]),     32'h0000_00B2);
    check("arst_mem_hi",    32'(mem0[16'h4001]),     32'h0000_0000);

    // Recovery after the aborted write.
    do_req(1'b0, 1'b0, 1'b1, 16'h4000, 16'h0000, lat, rdata);
    check("recover_latency", 32'(lat),   32'd3);
    check("recover_rdata",   32'(rdata), 32'h0000_00B2);

    check("we_without_cs", 32'(we_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator side of the single-port 8-bit memory bus: clk, 16-bit addr, bidirectional 8-bit data, write_enable, chip_select.
- Accepts byte or 16-bit word read/write requests from the CPU core (fetch/load-store) via a valid/ready handshake.
- Sequences them onto the byte-wide bus. Words are little-endian, low byte at addr, high byte at addr+1.
- Returns read data and write acknowledges as a one-cycle response pulse.

Parameters:
- ADDR_W, 16, bus and request address width.
- DATA_W, 8, bus data width; words are 2*DATA_W.
- WAIT_CYCLES, 0, extra cycles each bus beat is held before sampling/completing (0..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept; high only in IDLE.
- req_write  in  1  1=write, 0=read.
- req_word  in  1  1=16-bit access, 0=byte.
- req_addr  in  ADDR_W  start byte address.
- req_wdata  in  2*DATA_W  write data; bits [7:0] used for byte writes.
- resp_valid  out  1  one-cycle completion pulse (reads and writes).
- resp_rdata  out  2*DATA_W  read data, valid with resp_valid; byte reads zero-extended; 0 for writes.
- bus_addr  out  ADDR_W  memory address.
- bus_data  inout  DATA_W  driven only during write beats, else high-Z.
- bus_we  out  1  memory write enable; memory captures on posedge while high.
- bus_cs  out  1  memory chip select; memory drives bus_data combinationally when cs=1, we=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0.
  - bus_addr=0, bus_cs=0, bus_we=0, bus_data released (Z).
  - Effective immediately, including mid-transaction: no response is issued and a partial word write may leave only the low byte written.
- All outputs are registered; bus_data output enable is registered with bus_we.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - On posedge with req_valid=1, latch addr/write/word/wdata, go to BEAT0.
  - Drive bus_addr=req_addr, bus_cs=1, bus_we=req_write, and bus_data=wdata[7:0] if write.
- BEAT0: bus held stable for WAIT_CYCLES+1 cycles (wait counter).
  - On the final posedge: a read captures bus_data into rdata[7:0]; a write is captured by memory.
  - If word: go to BEAT1 with bus_addr=addr+1 (mod 2^ADDR_W, 0xFFFF wraps to 0x0000) and bus_data=wdata[15:8] on write.
  - If byte: go to RESP.
- BEAT1: same hold rule; on the final posedge a read captures rdata[15:8]; go to RESP.
- Leaving the last beat: bus_cs=0, bus_we=0, data released, bus_addr returns to 0.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata; next state IDLE.
- Latency with WAIT_CYCLES=0, measured from the accepting edge E:
  - byte: resp_valid high in cycle E+2.
  - word: resp_valid high in cycle E+3.
  - Each wait cycle adds 1 per beat.
- req_ready=0 from the accepting edge until back in IDLE. No back-to-back acceptance in RESP; maximum throughput is one request per 3 cycles (byte).
- Request inputs are ignored when req_ready=0; the requester holds them until accepted.
- Never bus_we=1 with bus_cs=0. Never drive bus_data while bus_we=0.
- Write beats: bus_addr and bus_data are stable for the whole beat, so the memory sees exactly one write per beat.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state enum (IDLE, BEAT0, BEAT1, RESP);
  - localparams for the address and data widths;
  - the word byte-order constant (little-endian).
- No sub-module needed; the wait counter and tristate driver stay inline.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, release -> req_ready=1, bus_cs=0, bus_we=0, bus_data Z, resp_valid=0.
- Word read, WAIT_CYCLES=0, memory[0x1000]=0x08, [0x1001]=0x60:
  - stimulus: read word 0x1000;
  - bus_addr 0x1000 then 0x1001 on consecutive cycles;
  - resp_valid at E+3 with resp_rdata=0x6008.
- Byte write then read:
  - write byte 0x5A to 0x0008 -> single bus_we pulse with addr 0x0008, data 0x5A;
  - resp_valid at E+2, resp_rdata=0;
  - read byte 0x0008 -> resp_rdata=0x005A.
- Word write at wrap boundary: write 0xBEEF to 0xFFFF -> memory[0xFFFF]=0xEF, memory[0x0000]=0xBE.
- WAIT_CYCLES=2 word read: each beat holds bus_addr for 3 cycles; resp_valid at E+7; req_ready low throughout.
- Reset mid-word-write: assert rst_n=0 during BEAT1 -> bus_cs/bus_we drop asynchronously, bus_data Z, no resp_valid, req_ready=1 after release.
